// File: rtl/shift_serializer_pkg.sv
// rtl/shift_serializer_pkg.sv - shared types, defaults and width helper for the serializer
package shift_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Counter width for a counter holding 0..range-1; never narrower than 1 bit.
  function automatic int cnt_width(input int range);
    return (range <= 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// rtl/shift_serializer_if.sv - parallel word valid/ready handshake into the serializer
interface shift_serializer_if
  import shift_pkg::*;
#(
  parameter int N = N_DEFAULT
) ();

  logic [N-1:0] DIN;
  logic         DVALID;
  logic         DREADY;

  modport master (output DIN, output DVALID, input DREADY);
  modport slave  (input DIN, input DVALID, output DREADY);

endinterface

// File: rtl/shift_serializer_fifo.sv
// rtl/shift_serializer_fifo.sv - synchronous DEPTH x N word FIFO feeding the serializer
module ser_fifo
  import shift_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push_i,
  input  logic [N-1:0]               data_i,
  input  logic                       pop_i,
  output logic [N-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = cnt_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A full FIFO refuses the push even when a pop frees a slot on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Word storage; contents are only ever written on an accepted push.
  always_ff @(posedge CLK) begin
    if (do_push && !RST) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointer and occupancy tracking; reset discards everything queued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= next_ptr(wr_q);
      end
      if (do_pop) begin
        rd_q <= next_ptr(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/shift_serializer.sv
// rtl/shift_serializer.sv - buffered parallel-in, serial-out driver for a serial-in shift register
module shift_serializer
  import shift_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int DEPTH     = 2,
  parameter int GAP       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic               CLK,
  input  logic               RST,
  shift_serializer_if.slave  bus,
  output logic               SOUT,
  output logic               SEN,
  output logic               BUSY,
  output logic               WORDDONE
);

  localparam int BW = cnt_width(N);
  localparam int GW = cnt_width(GAP);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
  localparam logic [BW-1:0] BIT_PENULT = BW'(N - 2);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t        state_q;
  logic [N-1:0]  shreg_q;
  logic [BW-1:0] bitcnt_q;
  logic [GW-1:0] gapcnt_q;
  logic          sout_q;
  logic          sen_q;
  logic          busy_q;
  logic          wdone_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [N-1:0]  fifo_head;
  logic [CW-1:0] fifo_count;
  logic          dready;
  logic          push;
  logic          pop;
  logic          last_bit;
  logic          gap_done;
  logic          load_slot;
  logic          go_idle;
  logic          busy_d;

  function automatic logic first_bit(input logic [N-1:0] w);
    return (MSB_FIRST != 0) ? w[N-1] : w[0];
  endfunction

  function automatic logic [N-1:0] shift_word(input logic [N-1:0] w);
    return (MSB_FIRST != 0) ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
  endfunction

  assign dready     = !fifo_full && !RST;
  assign bus.DREADY = dready;
  assign push       = bus.DVALID && dready;

  ser_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .data_i  (bus.DIN),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Decide whether this edge may load a new word, and what BUSY becomes.
  always_comb begin
    last_bit  = (state_q == ST_SHIFT) && (bitcnt_q == BIT_LAST);
    gap_done  = (state_q == ST_GAP) && (gapcnt_q == GAP_LAST);
    load_slot = (state_q == ST_IDLE) || (last_bit && (GAP == 0)) || gap_done;
    pop       = load_slot && !fifo_empty;
    go_idle   = load_slot && fifo_empty;
    busy_d    = !go_idle || push || (fifo_count > CW'(pop));
  end

  // Serializer FSM: load, shift one bit per edge, optional idle gap between words.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      sout_q   <= 1'b0;
      sen_q    <= 1'b0;
      busy_q   <= 1'b0;
      wdone_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      wdone_q <= 1'b0;
      if (pop) begin
        state_q  <= ST_SHIFT;
        shreg_q  <= shift_word(fifo_head);
        sout_q   <= first_bit(fifo_head);
        sen_q    <= 1'b1;
        bitcnt_q <= '0;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (!last_bit) begin
              shreg_q  <= shift_word(shreg_q);
              sout_q   <= first_bit(shreg_q);
              bitcnt_q <= bitcnt_q + BW'(1);
              wdone_q  <= (bitcnt_q == BIT_PENULT);
            end else if (GAP > 0) begin
              state_q  <= ST_GAP;
              gapcnt_q <= '0;
              sen_q    <= 1'b0;
              sout_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              sen_q   <= 1'b0;
              sout_q  <= 1'b0;
            end
          end
          ST_GAP: begin
            sen_q  <= 1'b0;
            sout_q <= 1'b0;
            if (gap_done) begin
              state_q <= ST_IDLE;
            end else begin
              gapcnt_q <= gapcnt_q + GW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            sen_q   <= 1'b0;
            sout_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SOUT     = sout_q;
  assign SEN      = sen_q;
  assign BUSY     = busy_q;
  assign WORDDONE = wdone_q;

endmodule

// File: tb/tb_shift_serializer.sv
// tb/tb_shift_serializer.sv - scoreboard bench for three serializer configurations
module tb_shift_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_serializer_if #(.N(4)) bus_a ();
  shift_serializer_if #(.N(4)) bus_b ();
  shift_serializer_if #(.N(4)) bus_c ();

  logic [2:0] sout_w, sen_w, busy_w, wd_w;

  // a: GAP=1 MSB first, b: GAP=0 MSB first, c: GAP=1 LSB first
  shift_serializer #(.N(4), .DEPTH(2), .GAP(1), .MSB_FIRST(1)) dut_a (
    .CLK(clk), .RST(rst), .bus(bus_a),
    .SOUT(sout_w[0]), .SEN(sen_w[0]), .BUSY(busy_w[0]), .WORDDONE(wd_w[0]));
  shift_serializer #(.N(4), .DEPTH(2), .GAP(0), .MSB_FIRST(1)) dut_b (
    .CLK(clk), .RST(rst), .bus(bus_b),
    .SOUT(sout_w[1]), .SEN(sen_w[1]), .BUSY(busy_w[1]), .WORDDONE(wd_w[1]));
  shift_serializer #(.N(4), .DEPTH(2), .GAP(1), .MSB_FIRST(0)) dut_c (
    .CLK(clk), .RST(rst), .bus(bus_c),
    .SOUT(sout_w[2]), .SEN(sen_w[2]), .BUSY(busy_w[2]), .WORDDONE(wd_w[2]));

  int total = 0;
  int bad = 0;

  // expected {WORDDONE, SOUT} per SEN cycle
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] qc[$];

  logic [3:0] q_a = '0;
  logic [3:0] q_c = '0;

  int   a_gap_run = 0;
  int   a_last_gap = -1;
  bit   a_in_gap = 0;
  int   b_run = 0;
  int   b_max_run = 0;
  int   b_wd_cnt = 0;
  int   waits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic qpush(input int d, input logic [1:0] e);
    case (d)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic qpop(input int d, output logic [1:0] e);
    case (d)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
  endtask

  function automatic logic get_rdy(input int d);
    case (d)
      0:       return bus_a.DREADY;
      1:       return bus_b.DREADY;
      default: return bus_c.DREADY;
    endcase
  endfunction

  task automatic set_in(input int d, input logic [3:0] w, input logic v);
    case (d)
      0:       begin bus_a.DIN = w; bus_a.DVALID = v; end
      1:       begin bus_b.DIN = w; bus_b.DVALID = v; end
      default: begin bus_c.DIN = w; bus_c.DVALID = v; end
    endcase
  endtask

  task automatic expect_word(input int d, input logic [3:0] w);
    logic b;
    for (int i = 0; i < 4; i++) begin
      b = (d != 2) ? w[3 - i] : w[i];
      qpush(d, {(i == 3), b});
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int d, input logic [3:0] w, output int nwait);
    logic rdy;
    nwait = 0;
    set_in(d, w, 1'b1);
    rdy = get_rdy(d);
    while (!rdy && nwait < 64) begin
      @(negedge clk);
      nwait++;
      rdy = get_rdy(d);
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d: DREADY stayed 0, expected 1", d);
    end else begin
      expect_word(d, w);
    end
    @(negedge clk);
    set_in(d, 4'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mon(input int d);
    logic [1:0] e;
    if (sen_w[d]) begin
      if (qsize(d) == 0) begin
        check($sformatf("sen_unexpected_dut%0d", d), {31'd0, sen_w[d]}, 32'd0);
      end else begin
        qpop(d, e);
        check($sformatf("sout_dut%0d", d), {31'd0, sout_w[d]}, {31'd0, e[0]});
        check($sformatf("worddone_dut%0d", d), {31'd0, wd_w[d]}, {31'd0, e[1]});
      end
    end else begin
      check($sformatf("idle_worddone_dut%0d", d), {31'd0, wd_w[d]}, 32'd0);
      check($sformatf("idle_sout_dut%0d", d), {31'd0, sout_w[d]}, 32'd0);
    end
  endtask

  // Monitor: scoreboard compare plus gap / run-length bookkeeping.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon(d);
    if (sen_w[0]) begin
      if (a_in_gap && a_gap_run > 0) a_last_gap = a_gap_run;
      a_in_gap = wd_w[0];
      a_gap_run = 0;
    end else if (a_in_gap) begin
      if (busy_w[0]) a_gap_run++;
      else begin a_in_gap = 0; a_gap_run = 0; end
    end
    if (sen_w[1]) begin
      b_run++;
      if (b_run > b_max_run) b_max_run = b_run;
    end else begin
      b_run = 0;
    end
    if (wd_w[1]) b_wd_cnt++;
  end

  // Downstream 4-bit serial-in register models
  always @(posedge clk) begin
    if (sen_w[0]) q_a <= {q_a[2:0], sout_w[0]};
    if (sen_w[2]) q_c <= {q_c[2:0], sout_w[2]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_in(0, 4'h0, 1'b0);
    set_in(1, 4'h0, 1'b0);
    set_in(2, 4'h0, 1'b0);
    idle(3);
    check("rst_sen", {31'd0, sen_w[0]}, 32'd0);
    check("rst_busy", {29'd0, busy_w}, 32'd0);
    check("rst_worddone", {29'd0, wd_w}, 32'd0);
    check("rst_dready", {31'd0, bus_a.DREADY}, 32'd0);
    rst = 1'b0;
    #1;
    check("dready_after_rst", {29'd0, bus_c.DREADY, bus_b.DREADY, bus_a.DREADY}, 32'd7);
    @(negedge clk);

    // single word 1011, latency and downstream contents
    send(0, 4'b1011, waits);
    check("lat_sen_before_first", {31'd0, sen_w[0]}, 32'd0);
    check("lat_busy", {31'd0, busy_w[0]}, 32'd1);
    @(negedge clk);
    check("lat_sen_first", {31'd0, sen_w[0]}, 32'd1);
    idle(8);
    check("downstream_q_1011", {28'd0, q_a}, 32'hB);
    check("busy_idle_after_word", {31'd0, busy_w[0]}, 32'd0);

    // two back-to-back words with one-cycle gap
    a_last_gap = -1;
    send(0, 4'b1100, waits);
    send(0, 4'b0011, waits);
    idle(14);
    check("gap_len", a_last_gap, 32'd1);
    check("downstream_q_0011", {28'd0, q_a}, 32'h3);

    // GAP=0: three words, continuous strobe, DREADY back-pressure
    send(1, 4'hA, waits);
    send(1, 4'h5, waits);
    send(1, 4'hF, waits);
    check("b_dready_full", {31'd0, bus_b.DREADY}, 32'd0);
    idle(16);
    check("b_run_len", b_max_run, 32'd12);
    check("b_worddone_cnt", b_wd_cnt, 32'd3);
    check("b_queue_drained", qsize(1), 32'd0);

    // full FIFO: fourth word waits for the first pop
    send(0, 4'h9, waits);
    send(0, 4'h6, waits);
    send(0, 4'h3, waits);
    check("a_dready_full", {31'd0, bus_a.DREADY}, 32'd0);
    send(0, 4'hC, waits);
    check("a_full_wait_cycles", waits, 32'd4);
    idle(30);
    check("a_queue_drained", qsize(0), 32'd0);

    // reset after two bits of 1111
    send(0, 4'b1111, waits);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sen", {31'd0, sen_w[0]}, 32'd0);
    check("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
    check("midrst_worddone", {31'd0, wd_w[0]}, 32'd0);
    check("midrst_dready", {31'd0, bus_a.DREADY}, 32'd0);
    check("midrst_abandoned_bits", qsize(0), 32'd2);
    qa.delete();
    rst = 1'b0;
    #1;
    check("midrst_dready_release", {31'd0, bus_a.DREADY}, 32'd1);
    @(negedge clk);
    send(0, 4'b0001, waits);
    idle(10);
    check("downstream_q_after_rst", {28'd0, q_a}, 32'h1);

    // LSB first: 0001 shifts out 1,0,0,0
    send(2, 4'b0001, waits);
    idle(10);
    check("downstream_q_lsb", {28'd0, q_c}, 32'h8);

    check("final_qa_empty", qsize(0), 32'd0);
    check("final_qb_empty", qsize(1), 32'd0);
    check("final_qc_empty", qsize(2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
